// File: rtl/dsp_mac_pipe_pkg.sv
// Shared DSP datapath constants and parameter-check helpers for MAC and filter tops.
package dsp_defs;

  localparam int DSP_A_MAX_WIDTH = 25;
  localparam int DSP_B_MAX_WIDTH = 18;
  localparam int DSP_P_MAX_WIDTH = 48;
  localparam int DSP_MAC_LATENCY = 3;

  function automatic bit dsp_mac_widths_ok(int a_w, int b_w, int p_w, int n_ch);
    return (a_w >= 1) && (a_w <= DSP_A_MAX_WIDTH) &&
           (b_w >= 1) && (b_w <= DSP_B_MAX_WIDTH) &&
           (p_w >= a_w + b_w) && (p_w <= DSP_P_MAX_WIDTH) &&
           (n_ch >= 1) && (n_ch <= 64);
  endfunction

  function automatic int dsp_chan_width(int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/dsp_mac_pipe_acc_bank.sv
// Per-channel accumulator bank: S3 read-modify-write, sticky overflow, result register.
// DSP_MAC_SATURATE_EN selects clamping instead of two's-complement wrap.
module dsp_mac_acc_bank
  import dsp_defs::*;
#(
  parameter int P_DATA_WIDTH = 48,
  parameter int PROD_WIDTH   = 43,
  parameter int NUM_CHANNELS = 1,
  parameter int CHAN_WIDTH   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           first,
  input  logic                           last,
  input  logic        [CHAN_WIDTH-1:0]   chan,
  input  logic signed [PROD_WIDTH-1:0]   prod,
  output logic                           out_valid,
  output logic        [CHAN_WIDTH-1:0]   out_chan,
  output logic signed [P_DATA_WIDTH-1:0] p,
  output logic                           ovf
);

  // Sized to the full index range so any chan value indexes safely; only
  // entries below NUM_CHANNELS are ever written.
  localparam int DEPTH = 2 ** CHAN_WIDTH;

  logic signed [P_DATA_WIDTH-1:0] acc [DEPTH];
  logic        [DEPTH-1:0]        ovf_flag;

  logic                           in_range;
  logic signed [P_DATA_WIDTH-1:0] prod_ext;
  logic signed [P_DATA_WIDTH-1:0] base;
  logic signed [P_DATA_WIDTH-1:0] sum;
  logic signed [P_DATA_WIDTH-1:0] result;
  logic                           add_ovf;
  logic                           ovf_next;

  always_comb begin
    in_range = {1'b0, chan} < (CHAN_WIDTH + 1)'(NUM_CHANNELS);
    prod_ext = P_DATA_WIDTH'(prod);
    base     = first ? '0 : acc[chan];
    sum      = base + prod_ext;
    add_ovf  = (base[P_DATA_WIDTH-1] == prod_ext[P_DATA_WIDTH-1]) &&
               (sum[P_DATA_WIDTH-1] != base[P_DATA_WIDTH-1]);
`ifdef DSP_MAC_SATURATE_EN
    if (add_ovf) begin
      result = base[P_DATA_WIDTH-1] ? {1'b1, {(P_DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(P_DATA_WIDTH-1){1'b1}}};
    end else begin
      result = sum;
    end
`else
    result = sum;
`endif
    ovf_next = (!first && ovf_flag[chan]) || add_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
      ovf_flag  <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      p         <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && in_range) begin
        acc[chan]      <= result;
        ovf_flag[chan] <= ovf_next;
        if (last) begin
          out_valid <= 1'b1;
          out_chan  <= chan;
          p         <= result;
          ovf       <= ovf_next;
        end
      end
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined multi-channel signed MAC: S1 operand regs, S2 product reg, S3 accumulator bank.
// Define DSP_MAC_SATURATE_EN to clamp on overflow instead of wrapping.
module dsp_mac_pipe
  import dsp_defs::*;
#(
  parameter  int A_DATA_WIDTH = 25,
  parameter  int B_DATA_WIDTH = 18,
  parameter  int P_DATA_WIDTH = 48,
  parameter  int NUM_CHANNELS = 1,
  localparam int CHAN_WIDTH   = dsp_chan_width(NUM_CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           first,
  input  logic                           last,
  input  logic        [CHAN_WIDTH-1:0]   chan,
  input  logic signed [A_DATA_WIDTH-1:0] a,
  input  logic signed [B_DATA_WIDTH-1:0] b,
  output logic                           out_valid,
  output logic        [CHAN_WIDTH-1:0]   out_chan,
  output logic signed [P_DATA_WIDTH-1:0] p,
  output logic                           ovf
);

  localparam int PROD_WIDTH = A_DATA_WIDTH + B_DATA_WIDTH;

  if (!dsp_mac_widths_ok(A_DATA_WIDTH, B_DATA_WIDTH, P_DATA_WIDTH, NUM_CHANNELS)) begin : g_bad_params
    $error("dsp_mac_pipe: unsupported width or channel parameters");
  end

  logic                           s1_valid, s1_first, s1_last;
  logic        [CHAN_WIDTH-1:0]   s1_chan;
  logic signed [A_DATA_WIDTH-1:0] s1_a;
  logic signed [B_DATA_WIDTH-1:0] s1_b;

  logic                           s2_valid, s2_first, s2_last;
  logic        [CHAN_WIDTH-1:0]   s2_chan;
  logic signed [PROD_WIDTH-1:0]   s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_chan  <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_chan  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_first <= first;
      s1_last  <= last;
      s1_chan  <= chan;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_chan  <= s1_chan;
    end
  end

  // Data registers carry no reset so they map onto the DSP48 AREG/BREG/MREG;
  // stale contents are harmless because the valid chain gates every use.
  always_ff @(posedge clk) begin
    s1_a    <= a;
    s1_b    <= b;
    s2_prod <= PROD_WIDTH'(s1_a) * PROD_WIDTH'(s1_b);
  end

  dsp_mac_acc_bank #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .PROD_WIDTH   (PROD_WIDTH),
    .NUM_CHANNELS (NUM_CHANNELS),
    .CHAN_WIDTH   (CHAN_WIDTH)
  ) u_acc_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_valid),
    .first     (s2_first),
    .last      (s2_last),
    .chan      (s2_chan),
    .prod      (s2_prod),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .p         (p),
    .ovf       (ovf)
  );

endmodule
